// File: rtl/icache_refill_responder.sv
// Memory-side refill responder: one AR request in, LEN+1 INCR data beats out of an
// internal word store, with DECERR on beats that fall outside the store window.
module icache_refill_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 1,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE = 'h8000_0000,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [LEN_WIDTH-1:0]  ar_len_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  localparam int STRIDE = DATA_WIDTH / 8;
  localparam int OFFB   = $clog2(STRIDE);
  localparam int IW     = $clog2(MEM_WORDS);
  localparam int CW     = $clog2(LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(MEM_WORDS * STRIDE);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRIDE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len, beat;
  logic [CW-1:0]         cnt;

  logic                  ar_fire, r_fire, load, first;
  logic [ADDR_WIDTH-1:0] cur_base, beat_addr, beat_off, wr_off;
  logic [LEN_WIDTH-1:0]  cur_len, next_k;
  logic                  beat_ok, wr_ok;

  assign ar_fire = ar_valid_i & ar_ready_o;
  assign r_fire  = r_valid_o & r_ready_i;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    first      = 1'b0;
    case (state)
      IDLE: if (ar_fire) begin
        if (LATENCY == 1) begin
          state_next = DATA;
          load       = 1'b1;
          first      = 1'b1;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: if (cnt == CW'(LATENCY - 1)) begin
        state_next = DATA;
        load       = 1'b1;
        first      = 1'b1;
      end
      DATA: if (r_fire) begin
        if (r_last_o) state_next = IDLE;
        else          load       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // With LATENCY==1 beat 0 is built straight from the request inputs.
  assign cur_base  = (state == IDLE) ? (ar_addr_i & ALIGN_MASK) : base_addr;
  assign cur_len   = (state == IDLE) ? ar_len_i : len;
  assign next_k    = first ? '0 : beat + LEN_WIDTH'(1);
  assign beat_addr = cur_base + (ADDR_WIDTH'(next_k) << OFFB);
  assign beat_off  = beat_addr - MEM_BASE;
  assign beat_ok   = beat_off < SPAN;
  assign wr_off    = wr_addr_i - MEM_BASE;
  assign wr_ok     = wr_off < SPAN;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ar_ready_o <= 1'b0;
      r_valid_o  <= 1'b0;
      r_data_o   <= '0;
      r_resp_o   <= 2'b00;
      r_last_o   <= 1'b0;
      base_addr  <= '0;
      len        <= '0;
      beat       <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_next;
      ar_ready_o <= (state_next == IDLE);
      // cnt counts cycles since the handshake, the handshake cycle being 0
      if (ar_fire) begin
        base_addr <= ar_addr_i & ALIGN_MASK;
        len       <= ar_len_i;
        cnt       <= CW'(1);
      end else if (state == WAIT) begin
        cnt <= cnt + CW'(1);
      end
      if (load) begin
        r_valid_o <= 1'b1;
        r_data_o  <= beat_ok ? mem[beat_off[OFFB +: IW]] : '0;
        r_resp_o  <= beat_ok ? 2'b00 : 2'b11;
        r_last_o  <= (next_k == cur_len);
        beat      <= next_k;
      end else if (r_fire) begin
        r_valid_o <= 1'b0;
      end
    end
  end

  // Store is not reset; preload is accepted in every cycle, reset included.
  always_ff @(posedge clk) begin
    if (wr_en_i && wr_ok) mem[wr_off[OFFB +: IW]] <= wr_data_i;
  end

endmodule
